// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: per-cycle PC / IF/ID / ID/EX enable and flush
// controls, plus the drain -> push -> vector interrupt-entry sequence.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal issue; handles branch flush, stalls, HLT, int_req
// DRAIN  | bubbles inserted so older instructions retire (cnt counts down)
// PUSH   | return PC written to stack once memory port is free
// VEC    | PC loads interrupt vector, int_ack pulses
// HALT   | front end frozen until int_req
module pipe_seq_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic branch_taken,
    input  logic mem_busy,
    input  logic ld_use_hz,
    input  logic halt_instr,
    input  logic int_req,
    output logic pc_en,
    output logic if_id_en,
    output logic if_id_flush,
    output logic id_ex_flush,
    output logic push_pc,
    output logic pc_sel_vec,
    output logic int_ack,
    output logic halted
);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_PUSH,
        S_VEC,
        S_HALT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (branch_taken || mem_busy || ld_use_hz) begin
                        state <= S_RUN;
                    end else if (halt_instr) begin
                        state <= S_HALT;
                    end else if (int_req) begin
                        state <= S_DRAIN;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (cnt == '0) state <= S_PUSH;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                S_PUSH: begin
                    if (!mem_busy) state <= S_VEC;
                end
                S_VEC: begin
                    if (!mem_busy) state <= S_RUN;
                end
                S_HALT: begin
                    if (int_req) begin
                        state <= S_DRAIN;
                        cnt   <= CNT_LOAD;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    // Outputs are decoded from state and live inputs so a stall acts in the same cycle.
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        push_pc     = 1'b0;
        pc_sel_vec  = 1'b0;
        int_ack     = 1'b0;
        halted      = 1'b0;
        if (!rst) begin
            case (state)
                S_RUN: begin
                    if (branch_taken) begin
                        pc_en       = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (mem_busy || ld_use_hz) begin
                        id_ex_flush = 1'b1;
                    end else if (halt_instr) begin
                        id_ex_flush = 1'b1;
                    end else if (int_req) begin
                        if_id_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    pc_en       = branch_taken;
                end
                S_PUSH: begin
                    push_pc = !mem_busy;
                end
                S_VEC: begin
                    pc_sel_vec  = 1'b1;
                    if_id_flush = 1'b1;
                    pc_en       = !mem_busy;
                    int_ack     = !mem_busy;
                end
                S_HALT: begin
                    halted      = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
